// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and completer FSM state encoding
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - word RAM, synchronous write, combinational read
module apb_mem_array #(
    parameter  int DEPTH = 256,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_completer_mem.sv
// rtl/apb_completer_mem.sv - APB completer backed by a word memory with wait states and error responses
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 1,
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [SEL_W-1:0]  pselx,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [APB_DW-1:0] pwdata,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              protocol_err,
    output logic [1:0]        state
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = 4;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    apb_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              perr_set, complete;

    logic              sel;
    logic [31:0]       offset;
    logic              live_bad;
    logic [AW-1:0]     live_idx;

    logic [AW-1:0]     cap_idx;
    logic              cap_write;
    logic              cap_bad;
    logic [APB_DW-1:0] cap_wdata;

    logic [AW-1:0]     rd_idx;
    logic              rd_bad, rd_write;
    logic [APB_DW-1:0] mem_rdata;
    logic              mem_we;

    logic              pready_d, pslverr_d;
    logic [APB_DW-1:0] prdata_d;

    assign sel      = pselx[SEL_INDEX];
    assign offset   = paddr - BASE_ADDR;
    assign live_bad = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (offset >= SPAN);
    assign live_idx = offset[2 +: AW];

    // With zero wait states READY is entered straight from the setup edge, before capture lands
    assign rd_idx   = (state_q == IDLE) ? live_idx : cap_idx;
    assign rd_bad   = (state_q == IDLE) ? live_bad : cap_bad;
    assign rd_write = (state_q == IDLE) ? pwrite   : cap_write;

    assign mem_we   = complete && cap_write && !cap_bad;

    apb_mem_array #(
        .DEPTH (DEPTH),
        .DW    (APB_DW)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .waddr (cap_idx),
        .wdata (cap_wdata),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        perr_set = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !penable) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = READY;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end else if (sel && penable) begin
                    perr_set = 1'b1;
                end
            end
            WAIT: begin
                if (!(sel && penable)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    perr_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                state_d = IDLE;
                if (sel && penable) begin
                    complete = 1'b1;
                end else begin
                    perr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // READY lasts one cycle, so the response is only ever loaded on the edge that enters it
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (state_d == READY) begin
            pready_d  = 1'b1;
            pslverr_d = rd_bad;
            prdata_d  = (rd_write || rd_bad) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pready       <= 1'b0;
            pslverr      <= 1'b0;
            prdata       <= '0;
            protocol_err <= 1'b0;
            cap_idx      <= '0;
            cap_write    <= 1'b0;
            cap_bad      <= 1'b0;
            cap_wdata    <= '0;
        end else begin
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
            if (perr_set) begin
                protocol_err <= 1'b1;
            end
            if (state_q == IDLE && sel && !penable) begin
                cap_idx   <= live_idx;
                cap_write <= pwrite;
                cap_bad   <= live_bad;
                cap_wdata <= pwdata;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// tb/tb_apb_completer_mem.sv - three completers on one APB bus checked against a word-array model
module tb_apb_completer_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    logic [31:0] prdata_v  [3];
    logic        pready_v  [3];
    logic        pslverr_v [3];
    logic        perr_v    [3];
    logic [1:0]  state_v   [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [3][256];
    logic [31:0] last_rd;
    logic        last_err;

    apb_completer_mem #(.DEPTH(256), .WAIT_CYCLES(1), .SEL_INDEX(0), .BASE_ADDR(BASE)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .protocol_err(perr_v[0]), .state(state_v[0])
    );

    apb_completer_mem #(.DEPTH(256), .WAIT_CYCLES(0), .SEL_INDEX(1), .BASE_ADDR(BASE)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .protocol_err(perr_v[1]), .state(state_v[1])
    );

    apb_completer_mem #(.DEPTH(256), .WAIT_CYCLES(3), .SEL_INDEX(2), .BASE_ADDR(BASE)) u_dut2 (
        .hclk(hclk), .hresetn(hresetn), .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]), .protocol_err(perr_v[2]), .state(state_v[2])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic bit model_bad(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < BASE) return 1'b1;
        if (a - BASE >= 32'd1024) return 1'b1;
        return 1'b0;
    endfunction

    // Called at #1 after a rising edge; leaves the bus idle at #1 after the completing edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int  w;
        bit  other;
        bit  bad;
        int  idx;
        bad   = model_bad(addr);
        idx   = int'((addr - BASE) >> 2) & 255;
        pselx   = 3'(1 << d);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        w     = 0;
        other = 1'b0;
        while (pready_v[d] !== 1'b1 && w < 20) begin
            for (int o = 0; o < 3; o++) if (o != d && pready_v[o] !== 1'b0) other = 1'b1;
            @(posedge hclk); #1;
            w++;
        end
        for (int o = 0; o < 3; o++) if (o != d && pready_v[o] !== 1'b0) other = 1'b1;
        last_rd  = prdata_v[d];
        last_err = pslverr_v[d];
        chk("wait_cycles", 32'(w), 32'(wait_of(d)));
        chk("other_pready", {31'd0, other}, 32'd0);
        chk("pslverr", {31'd0, pslverr_v[d]}, {31'd0, bad});
        if (!wr) chk("prdata", prdata_v[d], bad ? 32'd0 : model_mem[d][idx]);
        @(posedge hclk); #1;
        if (wr && !bad) model_mem[d][idx] = wd;
        chk("resp_cleared", {pready_v[d], pslverr_v[d], prdata_v[d][29:0]}, 32'd0);
        pselx   = 3'b000;
        penable = 1'b0;
    endtask

    logic [31:0] ra;

    initial begin
        hresetn = 1'b0;
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        repeat (2) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_prdata", prdata_v[d], 32'd0);
            chk("rst_pready", {31'd0, pready_v[d]}, 32'd0);
            chk("rst_pslverr", {31'd0, pslverr_v[d]}, 32'd0);
            chk("rst_perr", {31'd0, perr_v[d]}, 32'd0);
            chk("rst_state", {30'd0, state_v[d]}, 32'd0);
        end
        hresetn = 1'b1;
        @(posedge hclk); #1;

        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 16; w++)
                xfer(d, 1'b1, BASE + 32'(4 * w), $urandom);

        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0010, 32'd0);
        chk("wr_rd_data", last_rd, 32'hDEAD_BEEF);
        chk("wr_rd_err", {31'd0, last_err}, 32'd0);

        for (int w = 0; w < 4; w++) xfer(1, 1'b1, BASE + 32'(4 * w), 32'h1111_0000 + 32'(w));
        for (int w = 0; w < 4; w++) begin
            xfer(1, 1'b0, BASE + 32'(4 * w), 32'd0);
            chk("burst_data", last_rd, 32'h1111_0000 + 32'(w));
        end

        xfer(0, 1'b0, 32'h8000_0402, 32'd0);
        chk("misalign_err", {31'd0, last_err}, 32'd1);
        chk("misalign_data", last_rd, 32'd0);
        xfer(0, 1'b1, 32'h8000_0400, 32'h5555_AAAA);
        chk("range_err", {31'd0, last_err}, 32'd1);
        xfer(0, 1'b0, BASE, 32'd0);

        xfer(1, 1'b1, BASE + 32'h14, 32'hCAFE_F00D);
        xfer(0, 1'b0, BASE + 32'h14, 32'd0);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0:       ra = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                1:       ra = BASE - 4 * $urandom_range(1, 4);
                2:       ra = BASE + 32'h400 + 4 * $urandom_range(0, 8);
                default: ra = BASE + 4 * $urandom_range(0, 15);
            endcase
            xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ra, $urandom);
        end
        for (int d = 0; d < 3; d++) chk("no_perr", {31'd0, perr_v[d]}, 32'd0);

        // drop the select in the second wait cycle of a 3-wait write
        pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h0BAD_0BAD;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        pselx = 3'b000;
        @(posedge hclk); #1;
        penable = 1'b0;
        chk("abort_perr", {31'd0, perr_v[2]}, 32'd1);
        chk("abort_state", {30'd0, state_v[2]}, 32'd0);
        chk("abort_pready", {31'd0, pready_v[2]}, 32'd0);
        xfer(2, 1'b0, BASE + 32'hC, 32'd0);

        pselx = 3'b010; penable = 1'b1; pwrite = 1'b0; paddr = BASE;
        @(posedge hclk); #1;
        chk("nosetup_perr", {31'd0, perr_v[1]}, 32'd1);
        chk("nosetup_state", {30'd0, state_v[1]}, 32'd0);
        chk("nosetup_pready", {31'd0, pready_v[1]}, 32'd0);
        pselx = 3'b000; penable = 1'b0;
        @(posedge hclk); #1;

        pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h1C; pwdata = 32'h7777_7777;
        @(posedge hclk); #1;
        penable = 1'b1;
        chk("pre_rst_state", {30'd0, state_v[0]}, 32'd1);
        hresetn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("arst_state", {30'd0, state_v[d]}, 32'd0);
            chk("arst_perr", {31'd0, perr_v[d]}, 32'd0);
            chk("arst_pready", {31'd0, pready_v[d]}, 32'd0);
        end
        pselx = 3'b000; penable = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(0, 1'b0, BASE + 32'h1C, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
